// File: rtl/ram_sample_reader.sv
// Read-side engine for one channel of the circular mic-sample RAM: walks a delayed window
// of the buffer and streams the samples out, absorbing RAM latency and backpressure.
module ram_sample_reader #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16,
  parameter int unsigned LW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] delay,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] ram_adb,
  output logic          ram_ceb,
  output logic          ram_oce,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic          inflight_q, inflight_last_q;
  logic          done_q, done_d;

  logic [1:0][DW-1:0] fifo_data_q;
  logic [1:0]         fifo_last_q;
  logic               wr_idx_q, rd_idx_q;
  logic [1:0]         count_q;

  logic [AW-1:0] start_addr;
  logic          run_start, empty_start;
  logic          push, pop, credit_ok;
  logic [2:0]    occ_after;
  logic          issue, issue_last;
  logic [AW-1:0] issue_addr;
  logic [LW-1:0] issue_rem;

  assign start_addr  = base_addr - delay;
  assign run_start   = (state_q == StIdle) && start && (len != '0);
  assign empty_start = (state_q == StIdle) && start && (len == '0);

  assign push = inflight_q;
  assign pop  = m_valid && m_ready;

  // A slot freed by this cycle's pop can be refilled by the read issued now, which keeps the
  // 2-entry FIFO sufficient for one sample per cycle.
  assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign credit_ok = occ_after < 3'd2;

  // The first read goes out in the start cycle itself so the first sample is valid two
  // cycles later.
  assign issue      = run_start || ((state_q == StIssue) && credit_ok);
  assign issue_addr = (state_q == StIdle) ? start_addr : rd_ptr_q;
  assign issue_rem  = (state_q == StIdle) ? len : remaining_q;
  assign issue_last = (issue_rem == LW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    done_d      = empty_start || (pop && m_last);
    unique case (state_q)
      StIdle: begin
        if (run_start) begin
          rd_ptr_d    = start_addr + AW'(1);
          remaining_d = len - LW'(1);
          state_d     = issue_last ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + AW'(1);
          remaining_d = remaining_q - LW'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    ram_ceb = issue;
    ram_adb = issue ? issue_addr : '0;
    ram_oce = 1'b1;
    busy    = (state_q != StIdle);
    done    = done_q;
    m_valid = (count_q != 2'd0);
    m_data  = fifo_data_q[rd_idx_q];
    m_last  = m_valid && fifo_last_q[rd_idx_q];
  end

  // Read-latency pipeline: the last tag travels alongside the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
    end
  end

  // Skid FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_idx_q    <= 1'b0;
      rd_idx_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_idx_q] <= ram_dout;
        fifo_last_q[wr_idx_q] <= inflight_last_q;
        wr_idx_q              <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule
